// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: arbitrates entry/exit barriers, times out stalled
// cars and strobes an external occupancy counter when a car has passed.
module parking_gate_ctrl #(
  parameter int unsigned CAPACITY = 9,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_req_i,
  input  logic       entry_pass_i,
  input  logic       exit_req_i,
  input  logic       exit_pass_i,
  input  logic [3:0] count_i,
  output logic       count_up_o,
  output logic       count_down_o,
  output logic       entry_open_o,
  output logic       exit_open_o,
  output logic       full_o,
  output logic       timeout_err_o,
  output logic       underflow_err_o
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CAP      = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IN_OPEN,
    S_OUT_OPEN,
    S_IN_DONE,
    S_OUT_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             last_in_q, last_in_d;

  logic             entry_elig_c;
  logic             grant_in_c;
  logic             timeout_c;

  logic             entry_open_q;
  logic             exit_open_q;
  logic             count_up_q;
  logic             count_down_q;
  logic             full_q;
  logic             timeout_err_q;
  logic             underflow_err_q;

  // State, wait timer and round-robin memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      last_in_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      last_in_q <= last_in_d;
    end
  end

  // Next-state logic; entry eligibility uses the live count, not the lagging full flag.
  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    last_in_d    = last_in_q;
    timeout_c    = 1'b0;
    entry_elig_c = 1'b0;
    grant_in_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        entry_elig_c = entry_req_i && (count_i < CAP);
        if (entry_elig_c && exit_req_i) begin
          grant_in_c = !last_in_q;
        end else begin
          grant_in_c = entry_elig_c;
        end
        if (entry_elig_c || exit_req_i) begin
          state_d   = grant_in_c ? S_IN_OPEN : S_OUT_OPEN;
          tmr_d     = '0;
          last_in_d = grant_in_c;
        end
      end
      S_IN_OPEN: begin
        if (entry_pass_i) begin
          state_d = S_IN_DONE;
        end else if (tmr_q == TMR_LAST) begin
          state_d   = S_IDLE;
          timeout_c = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_OUT_OPEN: begin
        if (exit_pass_i) begin
          state_d = S_OUT_DONE;
        end else if (tmr_q == TMR_LAST) begin
          state_d   = S_IDLE;
          timeout_c = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_IN_DONE:  state_d = S_IDLE;
      S_OUT_DONE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Outputs registered from the next state so they align exactly with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_open_q    <= 1'b0;
      exit_open_q     <= 1'b0;
      count_up_q      <= 1'b0;
      count_down_q    <= 1'b0;
      full_q          <= 1'b0;
      timeout_err_q   <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      entry_open_q    <= (state_d == S_IN_OPEN);
      exit_open_q     <= (state_d == S_OUT_OPEN);
      count_up_q      <= (state_d == S_IN_DONE);
      count_down_q    <= (state_d == S_OUT_DONE) && (count_i != '0);
      full_q          <= (count_i >= CAP);
      timeout_err_q   <= timeout_c;
      underflow_err_q <= (state_d == S_OUT_DONE) && (count_i == '0);
    end
  end

  assign entry_open_o    = entry_open_q;
  assign exit_open_o     = exit_open_q;
  assign count_up_o      = count_up_q;
  assign count_down_o    = count_down_q;
  assign full_o          = full_q;
  assign timeout_err_o   = timeout_err_q;
  assign underflow_err_o = underflow_err_q;

endmodule
